// File: rtl/sa_cache_4way.sv
// Set-associative write-back data cache with NRU replacement and flop storage.
// Optional CACHE_PRELOAD_EN: reset preloads sets 0..3, ways 0..1 with tag = line = 4*way+set.
module sa_cache_4way #(
    parameter int unsigned INDEX_BITS      = 8,
    parameter int unsigned WAYS            = 4,
    parameter int unsigned TAG_BITS        = 22,
    parameter int unsigned OFFSET_BITS     = 2,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned LINE_SIZE_BYTES = 4,
    parameter int unsigned ADDRESS_WIDTH   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_req,
    input  logic [TAG_BITS-1:0]          i_tag,
    input  logic [INDEX_BITS-1:0]        i_index,
    input  logic [OFFSET_BITS-1:0]       i_offset,
    input  logic                         memRW,
    input  logic [DATA_WIDTH-1:0]        dataW,
    input  logic [LINE_SIZE_BYTES*8-1:0] i_memory_line,
    input  logic                         i_memory_response,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [LINE_SIZE_BYTES*8-1:0] line_data,
    output logic                         cache_miss,
    output logic                         o_evict,
    output logic [DATA_WIDTH-1:0]        o_evict_data,
    output logic [ADDRESS_WIDTH-1:0]     o_evict_addr
);
    localparam int unsigned SETS      = 2 ** INDEX_BITS;
    localparam int unsigned WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned LINE_BITS = LINE_SIZE_BYTES * 8;

    typedef enum logic [0:0] {StReady, StMiss} state_e;

    state_e state_q, state_d;

    logic [WAYS-1:0]      valid_q [SETS];
    logic [WAYS-1:0]      dirty_q [SETS];
    logic [WAYS-1:0]      use_q   [SETS];
    logic [TAG_BITS-1:0]  tag_q   [SETS][WAYS];
    logic [LINE_BITS-1:0] line_q  [SETS][WAYS];

    logic [WAYS-1:0]     hit;
    logic                any_hit;
    logic [WAY_BITS-1:0] hit_way;
    logic [WAY_BITS-1:0] victim;
    logic                victim_found;
    logic                victim_dirty;
    logic                do_hit;
    logic                do_fill;
    logic [WAY_BITS-1:0] upd_way;
    logic [WAYS-1:0]     upd_onehot;
    logic [WAYS-1:0]     use_set;
    logic [WAYS-1:0]     use_new;
    logic                unused_offset;

    assign unused_offset = ^i_offset;

    // Per-way compare, then a one-hot AND-OR mux of the hitting way's line.
    always_comb begin
        hit       = '0;
        line_data = '0;
        hit_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit[w] = valid_q[i_index][w] && (tag_q[i_index][w] == i_tag);
            if (hit[w]) begin
                line_data = line_data | line_q[i_index][w];
                hit_way   = WAY_BITS'(w);
            end
        end
    end

    assign any_hit = |hit;

    // Prefer the lowest invalid way, otherwise the lowest not-recently-used way.
    always_comb begin
        victim       = '0;
        victim_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !valid_q[i_index][w]) begin
                victim       = WAY_BITS'(w);
                victim_found = 1'b1;
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !use_q[i_index][w]) begin
                victim       = WAY_BITS'(w);
                victim_found = 1'b1;
            end
        end
    end

    assign victim_dirty = valid_q[i_index][victim] && dirty_q[i_index][victim];

    always_comb begin
        state_d = state_q;
        do_hit  = 1'b0;
        do_fill = 1'b0;
        unique case (state_q)
            StReady: begin
                if (i_req && any_hit) begin
                    do_hit = 1'b1;
                end else if (i_req) begin
                    state_d = StMiss;
                end
            end
            StMiss: begin
                if (i_memory_response) begin
                    do_fill = 1'b1;
                    state_d = StReady;
                end
            end
            default: state_d = StReady;
        endcase
    end

    // NRU: if marking this way would saturate the set, keep only this way marked.
    assign upd_way    = do_hit ? hit_way : victim;
    assign upd_onehot = WAYS'(1) << upd_way;
    assign use_set    = use_q[i_index] | upd_onehot;
    assign use_new    = (&use_set) ? upd_onehot : use_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StReady;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                use_q[s]   <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    line_q[s][w] <= '0;
`ifdef CACHE_PRELOAD_EN
                    if (s < 4 && w < 2) begin
                        valid_q[s][w] <= 1'b1;
                        tag_q[s][w]   <= TAG_BITS'(4 * w + s);
                        line_q[s][w]  <= LINE_BITS'(4 * w + s);
                    end
`endif
                end
            end
        end else begin
            if (do_hit || do_fill) begin
                use_q[i_index] <= use_new;
            end
            if (do_hit && memRW) begin
                line_q[i_index][hit_way]  <= dataW;
                dirty_q[i_index][hit_way] <= 1'b1;
            end
            if (do_fill) begin
                valid_q[i_index][victim] <= 1'b1;
                tag_q[i_index][victim]   <= i_tag;
                line_q[i_index][victim]  <= memRW ? dataW : i_memory_line;
                dirty_q[i_index][victim] <= memRW;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_data       <= '0;
            o_evict      <= 1'b0;
            o_evict_data <= '0;
            o_evict_addr <= '0;
        end else begin
            o_evict <= do_fill && victim_dirty;
            if (do_hit) begin
                o_data <= memRW ? dataW : line_data;
            end else if (do_fill) begin
                o_data <= memRW ? dataW : i_memory_line;
            end
            if (do_fill && victim_dirty) begin
                o_evict_data <= line_q[i_index][victim];
                o_evict_addr <= {tag_q[i_index][victim], i_index, OFFSET_BITS'(0)};
            end
        end
    end

    assign cache_miss = (state_q == StMiss);

endmodule

// File: tb/tb_sa_cache_4way.sv
// Directed and randomized bench for sa_cache_4way against a per-set array reference model.
module tb_sa_cache_4way;
    localparam int SETS = 256;
    localparam int WAYS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [21:0] i_tag = '0;
    logic [7:0]  i_index = '0;
    logic [1:0]  i_offset = '0;
    logic        memRW = 1'b0;
    logic [31:0] dataW = '0;
    logic [31:0] i_memory_line = '0;
    logic        i_memory_response = 1'b0;
    logic [31:0] o_data;
    logic [31:0] line_data;
    logic        cache_miss;
    logic        o_evict;
    logic [31:0] o_evict_data;
    logic [31:0] o_evict_addr;

    sa_cache_4way dut (
        .clk              (clk),
        .rst              (rst),
        .i_req            (i_req),
        .i_tag            (i_tag),
        .i_index          (i_index),
        .i_offset         (i_offset),
        .memRW            (memRW),
        .dataW            (dataW),
        .i_memory_line    (i_memory_line),
        .i_memory_response(i_memory_response),
        .o_data           (o_data),
        .line_data        (line_data),
        .cache_miss       (cache_miss),
        .o_evict          (o_evict),
        .o_evict_data     (o_evict_data),
        .o_evict_addr     (o_evict_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    bit          m_use   [SETS][WAYS];
    logic [21:0] m_tag   [SETS][WAYS];
    logic [31:0] m_line  [SETS][WAYS];
    bit          m_miss;
    bit          m_evict;
    logic [31:0] m_odata, m_edata, m_eaddr;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0; m_dirty[s][w] = 0; m_use[s][w] = 0;
                m_tag[s][w] = '0; m_line[s][w] = '0;
`ifdef CACHE_PRELOAD_EN
                if (s < 4 && w < 2) begin
                    m_valid[s][w] = 1;
                    m_tag[s][w]   = 22'(4 * w + s);
                    m_line[s][w]  = 32'(4 * w + s);
                end
`endif
            end
        end
        m_miss = 0; m_evict = 0; m_odata = '0; m_edata = '0; m_eaddr = '0;
    endtask

    function automatic int model_hit_way(input int s, input logic [21:0] t);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) return w;
        return -1;
    endfunction

    function automatic logic [31:0] model_line_data();
        int w;
        w = model_hit_way(int'(i_index), i_tag);
        return (w < 0) ? 32'h0 : m_line[i_index][w];
    endfunction

    task automatic touch(input int s, input int w);
        int cnt;
        m_use[s][w] = 1;
        cnt = 0;
        for (int k = 0; k < WAYS; k++) cnt += int'(m_use[s][k]);
        if (cnt == WAYS) begin
            for (int k = 0; k < WAYS; k++) m_use[s][k] = 0;
            m_use[s][w] = 1;
        end
    endtask

    function automatic int pick_victim(input int s);
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
        for (int w = 0; w < WAYS; w++) if (!m_use[s][w]) return w;
        return 0;
    endfunction

    task automatic model_step();
        int s, w;
        s = int'(i_index);
        m_evict = 0;
        if (!m_miss) begin
            if (i_req) begin
                w = model_hit_way(s, i_tag);
                if (w >= 0) begin
                    touch(s, w);
                    if (memRW) begin
                        m_line[s][w] = dataW; m_dirty[s][w] = 1; m_odata = dataW;
                    end else begin
                        m_odata = m_line[s][w];
                    end
                end else begin
                    m_miss = 1;
                end
            end
        end else if (i_memory_response) begin
            w = pick_victim(s);
            if (m_valid[s][w] && m_dirty[s][w]) begin
                m_evict = 1;
                m_edata = m_line[s][w];
                m_eaddr = {m_tag[s][w], i_index, 2'b00};
            end
            m_valid[s][w] = 1;
            m_tag[s][w]   = i_tag;
            m_line[s][w]  = memRW ? dataW : i_memory_line;
            m_dirty[s][w] = memRW;
            touch(s, w);
            m_odata = memRW ? dataW : i_memory_line;
            m_miss = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("line_data", line_data, model_line_data());
        model_step();
        @(posedge clk);
        #1;
        chk("o_data", o_data, m_odata);
        chk("cache_miss", cache_miss, m_miss);
        chk("o_evict", o_evict, m_evict);
        chk("o_evict_data", o_evict_data, m_edata);
        chk("o_evict_addr", o_evict_addr, m_eaddr);
    endtask

    task automatic access(input logic [21:0] t, input logic [7:0] ix, input logic rw,
                          input logic [31:0] wd, input logic [31:0] ml, input int lat);
        i_req = 1; i_tag = t; i_index = ix; memRW = rw; dataW = wd;
        i_memory_line = ml; i_memory_response = 0;
        tick();
        if (m_miss) begin
            repeat (lat) tick();
            i_memory_response = 1;
            tick();
            i_memory_response = 0;
        end
        i_req = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 0;
        model_reset();
        #1;
        chk("rst_o_data", o_data, 0);
        chk("rst_cache_miss", cache_miss, 0);
        chk("rst_o_evict", o_evict, 0);
        chk("rst_evict_data", o_evict_data, 0);
        chk("rst_evict_addr", o_evict_addr, 0);
        #2 rst = 1;
    endtask

    initial begin
        model_reset();
        do_reset();

`ifdef CACHE_PRELOAD_EN
        access(22'd6, 8'd2, 1'b0, 32'h0, 32'h0, 0);
        chk("pre_hit_miss", cache_miss, 0);
        chk("pre_hit_data", o_data, 32'd6);
        i_req = 1; i_tag = 22'd6; i_index = 8'd3; memRW = 0;
        tick();
        chk("pre_miss", cache_miss, 1);
        i_memory_response = 1; i_memory_line = 32'h0BAD_F00D;
        tick();
        i_memory_response = 0; i_req = 0;
`endif

        // Read miss, fill, reread
        i_req = 1; i_tag = 22'd5; i_index = 8'd3; memRW = 0; dataW = '0;
        tick();
        chk("rd_miss_set", cache_miss, 1);
        tick();
        i_memory_response = 1; i_memory_line = 32'hDEADBEEF;
        tick();
        i_memory_response = 0; i_req = 0;
        chk("fill_data", o_data, 32'hDEADBEEF);
        chk("fill_miss_clr", cache_miss, 0);
        chk("fill_no_evict", o_evict, 0);
        access(22'd5, 8'd3, 1'b0, 32'h0, 32'h0, 0);
        chk("reread_data", o_data, 32'hDEADBEEF);

        // Write hit
        access(22'd5, 8'd3, 1'b1, 32'h12345678, 32'h0, 0);
        chk("wr_hit_data", o_data, 32'h12345678);
        chk("wr_hit_nomiss", cache_miss, 0);
        access(22'd5, 8'd3, 1'b0, 32'h0, 32'h0, 0);
        chk("wr_readback", o_data, 32'h12345678);

        // Dirty eviction of way 0 in set 7
        for (int t = 1; t <= 4; t++) access(22'(t), 8'd7, 1'b0, 32'h0, 32'h100 + 32'(t), 1);
        access(22'd1, 8'd7, 1'b1, 32'hA5A5A5A5, 32'h0, 0);
        access(22'd2, 8'd7, 1'b0, 32'h0, 32'h0, 0);
        access(22'd3, 8'd7, 1'b0, 32'h0, 32'h0, 0);
        access(22'd9, 8'd7, 1'b0, 32'h0, 32'h99, 2);
        chk("evict_pulse", o_evict, 1);
        chk("evict_data", o_evict_data, 32'hA5A5A5A5);
        chk("evict_addr", o_evict_addr, {22'd1, 8'd7, 2'b00});
        tick();
        chk("evict_one_cycle", o_evict, 0);
        chk("evict_data_hold", o_evict_data, 32'hA5A5A5A5);

        // Reset mid-miss
        i_req = 1; i_tag = 22'd6; i_index = 8'd1; memRW = 0;
        tick();
        chk("mid_miss_set", cache_miss, 1);
        #2 rst = 0;
        model_reset();
        #1 chk("mid_miss_abort", cache_miss, 0);
        #2 rst = 1;
        i_tag = 22'd5; i_index = 8'd3;
        tick();
        chk("post_rst_miss", cache_miss, 1);
        i_memory_response = 1; i_memory_line = 32'hCAFEF00D;
        tick();
        i_memory_response = 0; i_req = 0;

        // Stray response while ready
        i_memory_response = 1; i_memory_line = 32'h11111111;
        tick();
        i_memory_response = 0;
        chk("stray_nomiss", cache_miss, 0);
        chk("stray_noevict", o_evict, 0);
        access(22'd5, 8'd3, 1'b0, 32'h0, 32'h0, 0);
        chk("stray_nochange", o_data, 32'hCAFEF00D);

        // Randomized traffic over a few sets and tags to force conflicts and evictions
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                i_memory_response = 1; i_memory_line = $urandom;
                tick();
                i_memory_response = 0;
            end else if (r == 1) begin
                tick();
            end else begin
                access(22'($urandom_range(0, 7)), 8'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), $urandom, $urandom,
                       int'($urandom_range(0, 3)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
